// File: rtl/prbs_checker.sv
// PRBS-7 (x^7+x^6+1) serial checker: searches for sequence alignment, then
// free-runs a reference LFSR and counts bit errors while locked.
module prbs_checker #(
  parameter int LOCK_COUNT  = 16,
  parameter int UNLOCK_ERRS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        din_valid,
  input  logic        clear_cnt,
  output logic        locked,
  output logic        err_pulse,
  output logic [31:0] err_count,
  output logic [31:0] bit_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int EW = $clog2(UNLOCK_ERRS + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [EW-1:0] ERR_LIMIT  = EW'(UNLOCK_ERRS);

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      hr_q, hr_d;
  logic [6:0]      hl_q, hl_d;
  logic [2:0]      fill_q, fill_d;
  logic [MW-1:0]   match_q, match_d;
  logic [5:0]      win_q, win_d;
  logic [EW-1:0]   werr_q, werr_d;
  logic            err_pulse_q, err_pulse_d;
  logic [31:0]     err_count_q, err_count_d;
  logic [31:0]     bit_count_q, bit_count_d;
  logic            pred_r_s;
  logic            pred_l_s;
  logic [EW-1:0]   werr_inc_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

  assign pred_r_s = hr_q[6] ^ hr_q[5];
  assign pred_l_s = hl_q[6] ^ hl_q[5];

  // Next-state logic: search/lock FSM, reference LFSR, window and error counters
  always_comb begin
    state_d     = state_q;
    hr_d        = hr_q;
    hl_d        = hl_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_d       = win_q;
    werr_d      = werr_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;
    werr_inc_s  = werr_q;

    if (din_valid) begin
      case (state_q)
        SEARCH: begin
          hr_d = {hr_q[5:0], din};
          if (fill_q != 3'd7) begin
            fill_d = fill_q + 3'd1;
          end else if ((din == pred_r_s) && (hr_q != 7'd0)) begin
            if (match_q == MATCH_LAST) begin
              state_d = LOCKED;
              hl_d    = {hr_q[5:0], din};
              match_d = '0;
              win_d   = 6'd0;
              werr_d  = '0;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          // Reference LFSR free-runs so a single bad bit yields a single error
          hl_d        = {hl_q[5:0], pred_l_s};
          bit_count_d = sat_inc(bit_count_q);
          if (din != pred_l_s) begin
            err_pulse_d = 1'b1;
            err_count_d = sat_inc(err_count_q);
            werr_inc_s  = werr_q + EW'(1);
          end else begin
            werr_inc_s  = werr_q;
          end
          if (werr_inc_s == ERR_LIMIT) begin
            state_d = SEARCH;
            fill_d  = 3'd0;
            match_d = '0;
            win_d   = 6'd0;
            werr_d  = '0;
          end else if (win_q == 6'd63) begin
            win_d  = 6'd0;
            werr_d = '0;
          end else begin
            win_d  = win_q + 6'd1;
            werr_d = werr_inc_s;
          end
        end
        default: begin
          state_d = SEARCH;
        end
      endcase
    end else begin
      err_pulse_d = 1'b0;
    end

    if (clear_cnt) begin
      err_count_d = 32'd0;
      bit_count_d = 32'd0;
    end else begin
      err_count_d = err_count_d;
      bit_count_d = bit_count_d;
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      hr_q        <= 7'd0;
      hl_q        <= 7'd0;
      fill_q      <= 3'd0;
      match_q     <= '0;
      win_q       <= 6'd0;
      werr_q      <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= 32'd0;
      bit_count_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      hr_q        <= hr_d;
      hl_q        <= hl_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_q       <= win_d;
      werr_q      <= werr_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: scenario table plus hand-written
// corner sequences, with a per-cycle scoreboard fed by a behavioural model.
module tb_prbs_checker;

  localparam int LOCK_COUNT  = 16;
  localparam int UNLOCK_ERRS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        clear_cnt = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [31:0] err_count;
  logic [31:0] bit_count;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        lk;
    logic        ep;
    logic [31:0] ec;
    logic [31:0] bc;
  } out_t;

  out_t exp_q[$];

  typedef struct {
    int nbits;
    int err_every;
    int err_off;
    bit tog;
    bit exp_lk;
    int exp_ec;
    int exp_bc;
  } scen_t;

  // Behavioural reference state
  logic        m_lock;
  logic        m_pulse;
  logic [6:0]  m_hr, m_hl;
  int          m_fill, m_match, m_win, m_werr;
  logic [31:0] m_ec, m_bc;
  logic [6:0]  gen_h;

  prbs_checker #(.LOCK_COUNT(LOCK_COUNT), .UNLOCK_ERRS(UNLOCK_ERRS)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_lock = 1'b0; m_pulse = 1'b0; m_hr = 7'd0; m_hl = 7'd0;
    m_fill = 0; m_match = 0; m_win = 0; m_werr = 0; m_ec = 32'd0; m_bc = 32'd0;
  endtask

  task automatic model_step(input logic v, input logic d, input logic clr);
    logic p;
    m_pulse = 1'b0;
    if (v && !m_lock) begin
      p = m_hr[6] ^ m_hr[5];
      if (m_fill < 7) m_fill++;
      else if (d == p && m_hr != 7'd0) begin
        m_match++;
        if (m_match == LOCK_COUNT) begin
          m_lock = 1'b1; m_match = 0; m_win = 0; m_werr = 0;
          m_hl = {m_hr[5:0], d};
        end
      end else m_match = 0;
      m_hr = {m_hr[5:0], d};
    end else if (v && m_lock) begin
      p = m_hl[6] ^ m_hl[5];
      m_hl = {m_hl[5:0], p};
      if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 32'd1;
      if (d != p) begin
        m_pulse = 1'b1;
        if (m_ec != 32'hFFFF_FFFF) m_ec = m_ec + 32'd1;
        m_werr++;
      end
      if (m_werr == UNLOCK_ERRS) begin
        m_lock = 1'b0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
      end else if (m_win == 63) begin
        m_win = 0; m_werr = 0;
      end else m_win++;
    end
    if (clr) begin
      m_ec = 32'd0; m_bc = 32'd0;
    end
  endtask

  task automatic check_out();
    out_t act, ex;
    act = {locked, err_pulse, err_count, bit_count};
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: no expected entry queued at t=%0t", $time);
    end else begin
      ex = exp_q.pop_front();
      if (act !== ex) begin
        n_fail++;
        $display("FAIL cycle t=%0t: got lk=%0b ep=%0b ec=%0d bc=%0d, want lk=%0b ep=%0b ec=%0d bc=%0d",
                 $time, act.lk, act.ep, act.ec, act.bc, ex.lk, ex.ep, ex.ec, ex.bc);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] ex);
    n_assert++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, ex);
    end
  endtask

  task automatic step(input logic v, input logic d, input logic clr);
    @(negedge clk);
    rst = 1'b0; din_valid = v; din = d; clear_cnt = clr;
    model_step(v, d, clr);
    exp_q.push_back({m_lock, m_pulse, m_ec, m_bc});
    @(posedge clk);
    #1;
    check_out();
  endtask

  // One valid bit from the reference generator, optionally corrupted
  task automatic tx(input logic flip, input logic clr);
    logic b;
    b = gen_h[6] ^ gen_h[5];
    gen_h = {gen_h[5:0], b};
    step(1'b1, b ^ flip, clr);
  endtask

  task automatic idle();
    step(1'b0, 1'($urandom), 1'b0);
  endtask

  // Reset with valid and clear also high to exercise reset priority
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; din_valid = 1'b1; clear_cnt = 1'b1; din = 1'b1;
    model_reset();
    exp_q.push_back({1'b0, 1'b0, 32'd0, 32'd0});
    @(posedge clk);
    #1;
    check_out();
    gen_h = 7'h7F;
  endtask

  task automatic lock_up(input bit tog);
    for (int i = 0; i < 22; i++) begin
      tx(1'b0, 1'b0);
      if (tog) idle();
    end
    chk("no_lock_after_22", {31'd0, locked}, 32'd0);
    tx(1'b0, 1'b0);
    chk("lock_after_23", {31'd0, locked}, 32'd1);
    chk("bc_zero_at_lock", bit_count, 32'd0);
    if (tog) idle();
  endtask

  scen_t scen[5];

  initial begin
    scen[0] = '{nbits: 100, err_every: 0,  err_off: 0,  tog: 1'b0, exp_lk: 1'b1, exp_ec: 0,  exp_bc: 100};
    scen[1] = '{nbits: 256, err_every: 21, err_off: 5,  tog: 1'b0, exp_lk: 1'b1, exp_ec: 12, exp_bc: 256};
    scen[2] = '{nbits: 40,  err_every: 10, err_off: 3,  tog: 1'b0, exp_lk: 1'b0, exp_ec: 4,  exp_bc: 34};
    scen[3] = '{nbits: 50,  err_every: 0,  err_off: 0,  tog: 1'b1, exp_lk: 1'b1, exp_ec: 0,  exp_bc: 50};
    scen[4] = '{nbits: 64,  err_every: 64, err_off: 63, tog: 1'b0, exp_lk: 1'b1, exp_ec: 1,  exp_bc: 64};
    gen_h = 7'h7F;
    model_reset();
    repeat (2) @(posedge clk);

    for (int s = 0; s < 5; s++) begin
      do_reset();
      lock_up(scen[s].tog);
      for (int i = 0; i < scen[s].nbits; i++) begin
        tx((scen[s].err_every != 0) && ((i % scen[s].err_every) == scen[s].err_off), 1'b0);
        if (scen[s].tog) idle();
      end
      chk($sformatf("scen%0d_locked", s), {31'd0, locked}, {31'd0, scen[s].exp_lk});
      chk($sformatf("scen%0d_err_count", s), err_count, 32'(scen[s].exp_ec));
      chk($sformatf("scen%0d_bit_count", s), bit_count, 32'(scen[s].exp_bc));
    end

    // Single flipped bit, then clear coincident with an error
    do_reset();
    lock_up(1'b0);
    repeat (10) tx(1'b0, 1'b0);
    tx(1'b1, 1'b0);
    chk("flip_pulse", {31'd0, err_pulse}, 32'd1);
    chk("flip_count", err_count, 32'd1);
    chk("flip_locked", {31'd0, locked}, 32'd1);
    tx(1'b0, 1'b0);
    chk("flip_pulse_drop", {31'd0, err_pulse}, 32'd0);
    chk("flip_count_hold", err_count, 32'd1);
    tx(1'b1, 1'b1);
    chk("clr_err_pulse", {31'd0, err_pulse}, 32'd1);
    chk("clr_wins_ec", err_count, 32'd0);
    chk("clr_wins_bc", bit_count, 32'd0);
    tx(1'b0, 1'b0);
    chk("count_after_clr", bit_count, 32'd1);

    // All-zero input never locks
    do_reset();
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (locked) chk("zeros_locked", 32'd1, 32'd0);
    end
    chk("zeros_final_locked", {31'd0, locked}, 32'd0);

    // Reset while locked with five errors, then relock from scratch
    do_reset();
    lock_up(1'b0);
    for (int i = 0; i < 90; i++) tx((i % 21) == 5, 1'b0);
    chk("pre_rst_ec", err_count, 32'd5);
    chk("pre_rst_locked", {31'd0, locked}, 32'd1);
    do_reset();
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_ec", err_count, 32'd0);
    chk("rst_bc", bit_count, 32'd0);
    lock_up(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
